// File: rtl/mem_responder.sv
// mem_responder: arbitrates datapath fetch (i_*) and load/store (d_*) requests onto one single-port bus.
// Latency: request seen in IDLE -> bus strobe next cycle -> ack two cycles after request on a zero-wait bus.
// Backpressure: requesters hold their request until ack; one bus transaction in flight, bus may stall up to TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst                       clock (rising edge) and asynchronous active-low reset
//   i_req, i_address               fetch request / word-aligned byte address, held until i_ack
//   instruction, i_ack             fetched word (held until next fetch) and one-cycle completion pulse
//   d_ren, d_wen, d_sel            load / store request (both high = store) with byte enables, held until d_ack
//   d_address, mem_store           data byte address and store data
//   memload, d_ack                 loaded word (held until next load) and one-cycle completion pulse
//   mem_err                        one-cycle pulse alongside i_ack/d_ack when the bus timed out
//   bus_adr/wdat/sel/we/stb        registered bus request, strobe held until bus_ack or timeout
//   bus_rdat, bus_ack              bus read data and completion
//
// Optional macro IFETCH_BUF_EN: one-entry fetch buffer; a repeated fetch of the buffered address
// is answered one cycle after the request without touching the bus.
module mem_responder #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic [31:0] instruction,
    output logic        i_ack,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_address,
    input  logic [31:0] mem_store,
    output logic [31:0] memload,
    output logic        d_ack,
    output logic        mem_err,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdat,
    output logic [3:0]  bus_sel,
    output logic        bus_we,
    output logic        bus_stb,
    input  logic [31:0] bus_rdat,
    input  logic        bus_ack
);

    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_ACK} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    state_t        state, state_nxt;
    kind_t         kind;
    logic [CW-1:0] counter;
    logic          accept_data;
    logic          accept_fetch;
    logic          bus_done;
    logic          bus_tmo;

`ifdef IFETCH_BUF_EN
    logic          buf_hit;
    logic          buf_vld;
    logic [31:0]   buf_adr;
    logic [31:0]   buf_dat;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept_data  = 1'b0;
        accept_fetch = 1'b0;
        bus_done     = 1'b0;
        bus_tmo      = 1'b0;
`ifdef IFETCH_BUF_EN
        buf_hit      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // Data port wins; a pending fetch is picked up in the next IDLE cycle.
                if (d_ren || d_wen) begin
                    accept_data = 1'b1;
                    state_nxt   = S_BUS;
                end else if (i_req) begin
`ifdef IFETCH_BUF_EN
                    if (buf_vld && (i_address == buf_adr)) begin
                        buf_hit   = 1'b1;
                        state_nxt = S_ACK;
                    end else begin
                        accept_fetch = 1'b1;
                        state_nxt    = S_BUS;
                    end
`else
                    accept_fetch = 1'b1;
                    state_nxt    = S_BUS;
`endif
                end
            end
            S_BUS: begin
                if (bus_ack) begin
                    bus_done  = 1'b1;
                    state_nxt = S_ACK;
                end else if (counter == CNT_LAST) begin
                    // This is the last strobe cycle; give up at the end of it.
                    bus_tmo   = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind        <= K_FETCH;
            counter     <= '0;
            instruction <= NOP_INSTR;
            memload     <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            mem_err     <= 1'b0;
            bus_adr     <= '0;
            bus_wdat    <= '0;
            bus_sel     <= '0;
            bus_we      <= 1'b0;
            bus_stb     <= 1'b0;
        end else begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            mem_err <= 1'b0;
            if (accept_data) begin
                kind    <= d_wen ? K_STORE : K_LOAD;
                bus_adr <= d_address;
                bus_sel <= d_sel;
                bus_we  <= d_wen;
                if (d_wen) bus_wdat <= mem_store;
                bus_stb <= 1'b1;
                counter <= '0;
            end
            if (accept_fetch) begin
                kind    <= K_FETCH;
                bus_adr <= i_address;
                bus_sel <= 4'hF;
                bus_we  <= 1'b0;
                bus_stb <= 1'b1;
                counter <= '0;
            end
            if (bus_done || bus_tmo) begin
                bus_stb <= 1'b0;
                mem_err <= bus_tmo;
                case (kind)
                    K_FETCH: begin
                        instruction <= bus_done ? bus_rdat : ERR_DATA;
                        i_ack       <= 1'b1;
                    end
                    K_LOAD: begin
                        memload <= bus_done ? bus_rdat : ERR_DATA;
                        d_ack   <= 1'b1;
                    end
                    default: d_ack <= 1'b1;    // store: memload untouched
                endcase
            end else if (state == S_BUS) begin
                counter <= counter + CW'(1);
            end
`ifdef IFETCH_BUF_EN
            if (buf_hit) begin
                instruction <= buf_dat;
                i_ack       <= 1'b1;
            end
`endif
        end
    end

`ifdef IFETCH_BUF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld <= 1'b0;
            buf_adr <= '0;
            buf_dat <= '0;
        end else begin
            if (bus_done && (kind == K_FETCH)) begin
                buf_vld <= 1'b1;
                buf_adr <= bus_adr;
                buf_dat <= bus_rdat;
            end else if (bus_tmo && (kind == K_FETCH)) begin
                buf_vld <= 1'b0;
            end
            // A store to the buffered word makes the copy stale.
            if (accept_data && d_wen && (d_address[31:2] == buf_adr[31:2])) buf_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int TMO     = 64;
    localparam int NEVER   = 1000;
    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IFETCH_BUF_EN
    localparam bit HAS_BUF = 1'b1;
`else
    localparam bit HAS_BUF = 1'b0;
`endif

    logic        clk, rst;
    logic        i_req, i_ack, d_ren, d_wen, d_ack, mem_err;
    logic [31:0] i_address, instruction, d_address, mem_store, memload;
    logic [3:0]  d_sel, bus_sel;
    logic [31:0] bus_adr, bus_wdat, bus_rdat;
    logic        bus_we, bus_stb, bus_ack;

    mem_responder dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_address(i_address), .instruction(instruction), .i_ack(i_ack),
        .d_ren(d_ren), .d_wen(d_wen), .d_sel(d_sel), .d_address(d_address),
        .mem_store(mem_store), .memload(memload), .d_ack(d_ack), .mem_err(mem_err),
        .bus_adr(bus_adr), .bus_wdat(bus_wdat), .bus_sel(bus_sel), .bus_we(bus_we),
        .bus_stb(bus_stb), .bus_rdat(bus_rdat), .bus_ack(bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int fails  = 0;
    int slave_wait = 0;

    logic [31:0] bus_mem [logic [29:0]];   // what the bus slave holds
    logic [31:0] ref_mem [logic [29:0]];   // what the reference model believes
    logic [31:0] exp_ins, exp_ml;
    bit          mbuf_vld;
    logic [31:0] mbuf_adr, mbuf_dat;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a[31:2]) ? bus_mem[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    endfunction

    // Bus slave: acks after slave_wait stall cycles of strobe, applies writes with byte enables.
    initial begin : bus_slave
        int scnt;
        scnt     = 0;
        bus_ack  = 1'b0;
        bus_rdat = '0;
        forever begin
            @(negedge clk);
            if (bus_ack) begin
                bus_ack = 1'b0;
            end else if (bus_stb) begin
                if (scnt >= slave_wait) begin
                    bus_ack  = 1'b1;
                    bus_rdat = bus_rd(bus_adr);
                    if (bus_we) bus_mem[bus_adr[31:2]] = merge(bus_rd(bus_adr), bus_wdat, bus_sel);
                    scnt = 0;
                end else begin
                    scnt++;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle. Drives one request, follows it to its ack,
    // checks the bus view, latency and returned data, then updates the model.
    task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                           input int w, input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                           input string nm);
        int n;
        bit got, hit, timed;
        logic own_ack, other_ack;
        hit   = HAS_BUF && (k == K_FETCH) && mbuf_vld && (mbuf_adr == a);
        timed = (w >= TMO);
        slave_wait = w;
        i_req = (k == K_FETCH); i_address = a;
        d_ren = (k == K_LOAD);  d_wen = (k == K_STORE);
        d_address = a; d_sel = s; mem_store = wd;
        n = 0; got = 1'b0;
        while (!got && n < TMO + 20) begin
            @(negedge clk);
            n++;
            own_ack   = (k == K_FETCH) ? i_ack : d_ack;
            other_ack = (k == K_FETCH) ? d_ack : i_ack;
            chk1({nm, "_other_ack"}, other_ack, 1'b0);
            if (n < exp_lat) begin
                chk1({nm, "_early_ack"}, own_ack, 1'b0);
                chk1({nm, "_stb"}, bus_stb, 1'b1);
                chk({nm, "_adr"}, bus_adr, a);
                chk({nm, "_sel"}, {28'b0, bus_sel}, {28'b0, (k == K_FETCH) ? 4'hF : s});
                chk1({nm, "_we"}, bus_we, k == K_STORE);
                if (k == K_STORE) chk({nm, "_wdat"}, bus_wdat, wd);
            end
            if (own_ack) got = 1'b1;
        end
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        chk({nm, "_latency"}, got ? 32'(n) : 32'(0), 32'(exp_lat));
        if (got) begin
            chk1({nm, "_stb_in_ack"}, bus_stb, 1'b0);
            chk1({nm, "_mem_err"}, mem_err, exp_e);
            if (k == K_FETCH) begin
                chk({nm, "_instruction"}, instruction, exp_d);
                chk({nm, "_memload_kept"}, memload, exp_ml);
                exp_ins = exp_d;
            end else begin
                chk({nm, "_memload"}, memload, exp_d);
                chk({nm, "_instruction_kept"}, instruction, exp_ins);
                if (k == K_LOAD) exp_ml = exp_d;
            end
        end
        if (k == K_STORE) begin
            if (!timed) ref_mem[a[31:2]] = merge(ref_rd(a), wd, s);
            if (mbuf_vld && (mbuf_adr[31:2] == a[31:2])) mbuf_vld = 1'b0;
        end else if (k == K_FETCH && !hit) begin
            if (timed) mbuf_vld = 1'b0;
            else begin mbuf_vld = 1'b1; mbuf_adr = a; mbuf_dat = exp_d; end
        end
        @(negedge clk);
        chk1({nm, "_ack_one_cycle"}, i_ack | d_ack | mem_err, 1'b0);
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waitc;
        logic [31:0] exp_d;     // instruction (fetch) / memload (load, store)
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int k, w, lat, d_at, i_at;
        bit hit, timed, fhit, e;
        logic [31:0] a, wd, ed;
        logic [3:0]  s;
        logic [31:0] addrs[5];

        vecs[0]  = '{K_FETCH, 32'h100, 32'h0,        4'hF, 0,     32'h00A00093, 1'b0, 2};
        vecs[1]  = '{K_LOAD,  32'h200, 32'h0,        4'hF, 0,     32'd30,       1'b0, 2};
        vecs[2]  = '{K_STORE, 32'h000, 32'd30,       4'hF, 3,     32'd30,       1'b0, 5};
        vecs[3]  = '{K_LOAD,  32'h000, 32'h0,        4'hF, 1,     32'd30,       1'b0, 3};
        vecs[4]  = '{K_STORE, 32'h000, 32'hAABBCCDD, 4'h5, 0,     32'd30,       1'b0, 2};
        vecs[5]  = '{K_LOAD,  32'h000, 32'h0,        4'h3, 2,     32'h00BB00DD, 1'b0, 4};
        vecs[6]  = '{K_LOAD,  32'h200, 32'h0,        4'hF, NEVER, ERR,          1'b1, TMO + 1};
        vecs[7]  = '{K_FETCH, 32'h104, 32'h0,        4'hF, NEVER, ERR,          1'b1, TMO + 1};
        vecs[8]  = '{K_FETCH, 32'h100, 32'h0,        4'hF, 0,     32'h00A00093, 1'b0, 2};
        vecs[9]  = '{K_FETCH, 32'h100, 32'h0,        4'hF, 4,     32'h00A00093, 1'b0, HAS_BUF ? 1 : 6};
        vecs[10] = '{K_STORE, 32'h100, 32'h12345678, 4'h8, 0,     ERR,          1'b0, 2};
        vecs[11] = '{K_FETCH, 32'h100, 32'h0,        4'hF, 0,     32'h12A00093, 1'b0, 2};

        bus_mem[30'h40] = 32'h00A00093; ref_mem[30'h40] = 32'h00A00093;
        bus_mem[30'h80] = 32'd30;       ref_mem[30'h80] = 32'd30;
        exp_ins = NOP; exp_ml = 32'h0; mbuf_vld = 1'b0; mbuf_adr = '0; mbuf_dat = '0;

        rst = 1'b0; i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        i_address = '0; d_address = '0; d_sel = '0; mem_store = '0;
        repeat (2) @(negedge clk);
        chk("reset_instruction", instruction, NOP);
        chk("reset_memload", memload, 32'h0);
        chk("reset_bus_adr", bus_adr, 32'h0);
        chk("reset_bus_wdat", bus_wdat, 32'h0);
        chk1("reset_stb", bus_stb, 1'b0);
        chk1("reset_we", bus_we, 1'b0);
        chk1("reset_acks", i_ack | d_ack | mem_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk1("idle_stb", bus_stb, 1'b0);

        for (int i = 0; i < 12; i++)
            run_txn(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].sel, vecs[i].waitc,
                    vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat, $sformatf("vec%0d", i));

        // Fetch and load presented together: load first, fetch picked up in the IDLE cycle after d_ack.
        fhit = HAS_BUF && mbuf_vld && (mbuf_adr == 32'h100);
        slave_wait = 0;
        i_req = 1'b1; i_address = 32'h100;
        d_ren = 1'b1; d_address = 32'h200; d_sel = 4'hF;
        d_at = 0; i_at = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            chk1("sim_dual_ack", i_ack & d_ack, 1'b0);
            if (n == 3) chk1("sim_stb_idle_gap", bus_stb, 1'b0);
            if (n == 4) chk1("sim_fetch_stb", bus_stb, !fhit);
            if (d_ack && d_at == 0) begin d_at = n; d_ren = 1'b0; end
            if (i_ack && i_at == 0) begin i_at = n; i_req = 1'b0; end
        end
        chk("sim_d_ack_cycle", 32'(d_at), 32'd2);
        chk("sim_i_ack_cycle", 32'(i_at), fhit ? 32'd4 : 32'd5);
        chk("sim_memload", memload, ref_rd(32'h200));
        chk("sim_instruction", instruction, ref_rd(32'h100));
        exp_ml = ref_rd(32'h200); exp_ins = ref_rd(32'h100);
        if (!fhit) begin mbuf_vld = 1'b1; mbuf_adr = 32'h100; mbuf_dat = ref_rd(32'h100); end

        // Reset while a load is stalled on the bus.
        slave_wait = NEVER;
        d_ren = 1'b1; d_address = 32'h4; d_sel = 4'hF;
        repeat (3) @(negedge clk);
        chk1("rst_mid_stb_before", bus_stb, 1'b1);
        rst = 1'b0;
        #1;
        chk1("rst_mid_stb", bus_stb, 1'b0);
        chk("rst_mid_instruction", instruction, NOP);
        chk("rst_mid_memload", memload, 32'h0);
        chk1("rst_mid_acks", i_ack | d_ack | mem_err, 1'b0);
        d_ren = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk1("rst_after_acks", i_ack | d_ack | mem_err, 1'b0);
            chk1("rst_after_stb", bus_stb, 1'b0);
        end
        exp_ins = NOP; exp_ml = 32'h0; mbuf_vld = 1'b0;

        // Randomized traffic against the reference model.
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h100; addrs[3] = 32'h104; addrs[4] = 32'h200;
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 2);
            a  = addrs[$urandom_range(0, 4)];
            wd = $urandom;
            s  = 4'($urandom_range(1, 15));
            w  = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 4);
            hit   = HAS_BUF && (k == K_FETCH) && mbuf_vld && (mbuf_adr == a);
            timed = (w >= TMO);
            if (k == K_STORE) ed = exp_ml;
            else if (hit)     ed = mbuf_dat;
            else if (timed)   ed = ERR;
            else              ed = ref_rd(a);
            e   = timed && !hit;
            lat = hit ? 1 : (timed ? TMO + 1 : w + 2);
            run_txn(k, a, wd, s, w, ed, e, lat, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
